// File: rtl/pokey_serout.sv
// rtl/pokey_serout.sv - POKEY serial-output framer (SEROUT holding register + 10-bit frame shifter)
//
// Purpose:
//   Accepts SEROUT writes into a holding register, transfers the byte into a
//   10-bit frame shifter (start 0, 8 data LSB-first, stop 1) on a bit-clock
//   enable and drives the serial data line one bit per bit_en.
//   Back-to-back frames follow with no idle mark bit when the holding
//   register has been refilled before the stop bit completes.
//
// Optional feature macro: SEROUT_BREAK_EN
//   When defined, the force_break input exists and forces sod low while
//   high, without disturbing framing state.
//
// Ports:
//   clk         in   system clock, rising edge
//   rst_n       in   asynchronous active-low reset
//   bit_en      in   one-clk pulse per bit period; all framing advances on it
//   wr_en       in   one-clk SEROUT write strobe (accepted every clk)
//   wr_data     in   [7:0] byte to transmit
//   force_break in   (SEROUT_BREAK_EN only) hold sod at 0 while high
//   sod         out  serial data out, idle/mark = 1
//   sout_req    out  one-clk pulse when the holding register is emptied
//   xmt_done    out  shifter idle and holding register empty
//   busy        out  frame in progress

module pokey_serout (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       bit_en,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
`ifdef SEROUT_BREAK_EN
  input  logic       force_break,
`endif
  output logic       sod,
  output logic       sout_req,
  output logic       xmt_done,
  output logic       busy
);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  localparam logic [3:0] LAST_BIT = 4'd9;

  state_t      state,     state_n;
  logic [7:0]  hold,      hold_n;
  logic        hold_full, hold_full_n;
  logic [9:0]  shreg,     shreg_n;
  logic [3:0]  cnt,       cnt_n;
  logic        sout_req_n;
  logic        transfer;
  logic        framer_sod;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      hold      <= 8'h00;
      hold_full <= 1'b0;
      shreg     <= 10'h3FF;
      cnt       <= 4'd0;
      sout_req  <= 1'b0;
    end else begin
      state     <= state_n;
      hold      <= hold_n;
      hold_full <= hold_full_n;
      shreg     <= shreg_n;
      cnt       <= cnt_n;
      sout_req  <= sout_req_n;
    end
  end

  always_comb begin
    state_n     = state;
    hold_n      = hold;
    hold_full_n = hold_full;
    shreg_n     = shreg;
    cnt_n       = cnt;
    sout_req_n  = 1'b0;
    transfer    = 1'b0;

    case (state)
      IDLE: begin
        if (bit_en && hold_full) begin
          transfer = 1'b1;
        end
      end
      SHIFT: begin
        if (bit_en) begin
          if (cnt < LAST_BIT) begin
            shreg_n = {1'b1, shreg[9:1]};
            cnt_n   = cnt + 4'd1;
          end else if (hold_full) begin
            // Stop bit just finished and a byte is waiting: chain directly.
            transfer = 1'b1;
          end else begin
            state_n = IDLE;
          end
        end
      end
      default: state_n = IDLE;
    endcase

    // Transfer uses the pre-write hold value; a same-cycle write lands
    // afterwards and keeps hold_full set.
    if (transfer) begin
      shreg_n     = {1'b1, hold, 1'b0};
      cnt_n       = 4'd0;
      state_n     = SHIFT;
      hold_full_n = 1'b0;
      sout_req_n  = 1'b1;
    end

    if (wr_en) begin
      hold_n      = wr_data;
      hold_full_n = 1'b1;
    end
  end

  assign framer_sod = (state == SHIFT) ? shreg[0] : 1'b1;

`ifdef SEROUT_BREAK_EN
  assign sod = framer_sod & ~force_break;
`else
  assign sod = framer_sod;
`endif

  assign busy     = (state == SHIFT);
  assign xmt_done = (state == IDLE) & ~hold_full;

endmodule

// File: tb/tb_pokey_serout.sv
// tb/tb_pokey_serout.sv - self-checking bench for pokey_serout

module tb_pokey_serout;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       bit_en;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       force_break;
  logic       sod, sout_req, xmt_done, busy;

  pokey_serout dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .bit_en      (bit_en),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
`ifdef SEROUT_BREAK_EN
    .force_break (force_break),
`endif
    .sod         (sod),
    .sout_req    (sout_req),
    .xmt_done    (xmt_done),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: the line is a queue of pending bits; the head is what
  // sod should show. Holding register is a byte plus a full flag.
  bit         line_q[$];
  logic [7:0] m_hold;
  bit         m_full;
  bit         m_req;
  logic       sod_seen;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    line_q.delete();
    m_hold = 8'h00;
    m_full = 1'b0;
    m_req  = 1'b0;
  endtask

  task automatic check_outputs();
    logic exp_sod;
    exp_sod = (line_q.size() > 0) ? line_q[0] : 1'b1;
`ifdef SEROUT_BREAK_EN
    if (force_break) exp_sod = 1'b0;
`endif
    check("sod",      sod,      exp_sod);
    check("busy",     busy,     line_q.size() > 0);
    check("xmt_done", xmt_done, (line_q.size() == 0) && !m_full);
    check("sout_req", sout_req, m_req);
    sod_seen = sod;
  endtask

  // One clock: check outputs at negedge, drive inputs, advance model at posedge.
  task automatic step(input bit be, input bit we, input logic [7:0] d);
    bit xfer;
    @(negedge clk);
    check_outputs();
    bit_en  = be;
    wr_en   = we;
    wr_data = d;
    @(posedge clk);
    xfer = be && m_full && (line_q.size() <= 1);
    if (be && line_q.size() > 0) void'(line_q.pop_front());
    if (xfer) begin
      line_q.push_back(1'b0);
      for (int i = 0; i < 8; i++) line_q.push_back(m_hold[i]);
      line_q.push_back(1'b1);
    end
    m_req = xfer;
    if (we) begin
      m_hold = d;
      m_full = 1'b1;
    end else if (xfer) begin
      m_full = 1'b0;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    check_outputs();
    bit_en = 1'b0;
    wr_en  = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check("rst_sod",      sod,      1'b1);
    check("rst_busy",     busy,     1'b0);
    check("rst_xmt_done", xmt_done, 1'b1);
    check("rst_sout_req", sout_req, 1'b0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [9:0] frame;
    int         req_cnt;

    rst_n       = 1'b0;
    bit_en      = 1'b0;
    wr_en       = 1'b0;
    wr_data     = 8'h00;
    force_break = 1'b0;
    model_reset();
    #12;
    check("reset_sod",      sod,      1'b1);
    check("reset_busy",     busy,     1'b0);
    check("reset_xmt_done", xmt_done, 1'b1);
    check("reset_sout_req", sout_req, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // 0xA5 with bit_en every 4 clks; capture the bit shown after each bit_en.
    step(1'b0, 1'b1, 8'hA5);
    idle(2);
    for (int b = 0; b < 10; b++) begin
      step(1'b1, 1'b0, 8'h00);
      step(1'b0, 1'b0, 8'h00);
      frame[b] = sod_seen;
      idle(2);
    end
    check("a5_frame", {22'd0, frame}, 32'h34A);
    step(1'b1, 1'b0, 8'h00);
    idle(2);
    check("a5_done", xmt_done, 1'b1);

    // 0x3C then 0xFF mid-frame: back-to-back, count sout_req pulses.
    req_cnt = 0;
    step(1'b0, 1'b1, 8'h3C);
    step(1'b1, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) begin
      step(1'b1, (i == 1), 8'hFF);
      if (sod_seen === 1'b0 || sout_req === 1'b1) req_cnt += 0;
    end
    for (int i = 0; i < 24; i++) begin
      step(1'b1, 1'b0, 8'h00);
      if (sout_req === 1'b1) req_cnt++;
    end
    check("b2b_req_cnt", req_cnt, 1);

    // Overwrite while busy: 0x11 lost, 0x22 framed.
    step(1'b0, 1'b1, 8'h5A);
    step(1'b1, 1'b0, 8'h00);
    step(1'b1, 1'b1, 8'h11);
    step(1'b1, 1'b1, 8'h22);
    idle(1);
    check("ovw_hold_full", xmt_done, 1'b0);
    repeat (24) step(1'b1, 1'b0, 8'h00);

    // Write coincident with transferring bit_en.
    step(1'b0, 1'b1, 8'h81);
    step(1'b1, 1'b1, 8'h7E);
    repeat (24) step(1'b1, 1'b0, 8'h00);

    // Reset at bit 4 of 0x55, then a fresh frame.
    step(1'b0, 1'b1, 8'h55);
    repeat (5) step(1'b1, 1'b0, 8'h00);
    apply_reset();
    step(1'b0, 1'b1, 8'hC3);
    repeat (14) step(1'b1, 1'b0, 8'h00);

`ifdef SEROUT_BREAK_EN
    step(1'b0, 1'b1, 8'hF0);
    repeat (3) step(1'b1, 1'b0, 8'h00);
    force_break = 1'b1;
    repeat (4) step(1'b1, 1'b0, 8'h00);
    force_break = 1'b0;
    repeat (8) step(1'b1, 1'b0, 8'h00);
`endif

    // Randomized traffic with varying bit-period density.
    for (int i = 0; i < 3000; i++) begin
      int dens;
      dens = (i / 500) % 3;
      step(($urandom_range(0, dens * 3 + 1) == 0),
           ($urandom_range(0, 11) == 0),
           8'($urandom));
`ifdef SEROUT_BREAK_EN
      if ($urandom_range(0, 40) == 0) force_break = ~force_break;
`endif
      if ($urandom_range(0, 700) == 0) apply_reset();
    end
    idle(1);
    @(negedge clk);
    check_outputs();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
